// File: rtl/seq_game_pkg.sv
// Shared state codes and default parameters for the sequence-memory game controller.
package seq_game_pkg;

  typedef logic [3:0] estado_t;

  localparam estado_t INICIAL       = 4'd0;
  localparam estado_t PREPARA       = 4'd1;
  localparam estado_t NOVA_RODADA   = 4'd2;
  localparam estado_t CARREGA       = 4'd3;
  localparam estado_t MOSTRA        = 4'd4;
  localparam estado_t APAGA         = 4'd5;
  localparam estado_t INTERVALO     = 4'd6;
  localparam estado_t PROX_POS      = 4'd7;
  localparam estado_t INICIO_JOGADA = 4'd8;
  localparam estado_t ESPERA        = 4'd9;
  localparam estado_t REGISTRA      = 4'd10;
  localparam estado_t COMPARA       = 4'd11;
  localparam estado_t PROX_JOGADA   = 4'd12;
  localparam estado_t FIM_RODADA    = 4'd13;
  localparam estado_t ACERTO        = 4'd14;
  localparam estado_t ERRO          = 4'd15;

  localparam int N_BTN_DEF          = 4;
  localparam int ADDR_W_DEF         = 4;
  localparam int RODADAS_DEF        = 16;
  localparam int SHOW_CYCLES_DEF    = 50;
  localparam int OFF_CYCLES_DEF     = 25;
  localparam int TIMEOUT_CYCLES_DEF = 5000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq_game_timer.sv
// Shared cycle timer: clears on zera, counts on conta; fim flags the last counted cycle
// (the cycle in which the count equals limite-1), so a state holding conta lasts exactly limite clocks.
module seq_game_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         zera,
  input  logic         conta,
  input  logic [W-1:0] limite,
  output logic         fim
);

  logic [W-1:0] valor;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valor <= '0;
    end else if (zera) begin
      valor <= '0;
    end else if (conta) begin
      valor <= valor + W'(1);
    end
  end

  assign fim = conta && (valor == (limite - W'(1)));

endmodule

// File: rtl/seq_game_control.sv
// Sequence-memory game FSM: shows rounds of one-hot steps on leds, then checks player presses.
// Optional play timeout in ESPERA is enabled by defining SEQ_GAME_TIMEOUT_EN.
module seq_game_control
  import seq_game_pkg::*;
#(
  parameter int N_BTN          = N_BTN_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int RODADAS        = RODADAS_DEF,
  parameter int SHOW_CYCLES    = SHOW_CYCLES_DEF,
  parameter int OFF_CYCLES     = OFF_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              iniciar,
  input  logic [N_BTN-1:0]  botoes,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [N_BTN-1:0]  mem_data,
  output logic [N_BTN-1:0]  leds,
  output logic              acertou,
  output logic              errou,
  output logic              pronto,
  output logic [3:0]        db_estado,
  output logic [ADDR_W-1:0] db_rodada,
  output logic              db_timeout
);

  localparam int TW = $clog2(max3(SHOW_CYCLES, OFF_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [ADDR_W-1:0] ULTIMA = ADDR_W'(RODADAS - 1);
`ifdef SEQ_GAME_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  estado_t           estado, prox;
  logic [ADDR_W-1:0] rodada, pos;
  logic [N_BTN-1:0]  jogada_reg;
  logic              botoes_any_q;
  logic              jogada;
  logic              t_zera, t_conta, t_fim;
  logic [TW-1:0]     t_limite;

  // A play is only a fresh rising edge of any button, so holding a key never re-triggers.
  assign jogada = (|botoes) && !botoes_any_q;

  assign t_zera  = (estado == CARREGA) || (estado == APAGA) ||
                   (estado == INICIO_JOGADA) || (estado == PROX_JOGADA);
  assign t_conta = (estado == MOSTRA) || (estado == INTERVALO) ||
                   (TIMEOUT_EN && (estado == ESPERA));

  always_comb begin
    t_limite = TW'(TIMEOUT_CYCLES);
    if (estado == MOSTRA)         t_limite = TW'(SHOW_CYCLES);
    else if (estado == INTERVALO) t_limite = TW'(OFF_CYCLES);
  end

  seq_game_timer #(.W(TW)) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .zera    (t_zera),
    .conta   (t_conta),
    .limite  (t_limite),
    .fim     (t_fim)
  );

  always_comb begin
    prox = estado;
    case (estado)
      INICIAL:       if (iniciar) prox = PREPARA;
      PREPARA:       prox = NOVA_RODADA;
      NOVA_RODADA:   prox = CARREGA;
      CARREGA:       prox = MOSTRA;
      MOSTRA:        if (t_fim) prox = APAGA;
      APAGA:         prox = INTERVALO;
      INTERVALO:     if (t_fim) prox = (pos == rodada) ? INICIO_JOGADA : PROX_POS;
      PROX_POS:      prox = CARREGA;
      INICIO_JOGADA: prox = ESPERA;
      ESPERA: begin
        // t_fim can only rise here when the timeout feature counts; a play wins a tie.
        if (jogada)     prox = REGISTRA;
        else if (t_fim) prox = ERRO;
      end
      REGISTRA:      prox = COMPARA;
      COMPARA: begin
        if (jogada_reg != mem_data) prox = ERRO;
        else if (pos == rodada)     prox = FIM_RODADA;
        else                        prox = PROX_JOGADA;
      end
      PROX_JOGADA:   prox = ESPERA;
      FIM_RODADA:    prox = (rodada == ULTIMA) ? ACERTO : NOVA_RODADA;
      ACERTO:        if (iniciar) prox = PREPARA;
      ERRO:          if (iniciar) prox = PREPARA;
      default:       prox = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado       <= INICIAL;
      rodada       <= '0;
      pos          <= '0;
      leds         <= '0;
      jogada_reg   <= '0;
      botoes_any_q <= 1'b0;
    end else begin
      estado       <= prox;
      botoes_any_q <= |botoes;
      case (estado)
        PREPARA:       rodada <= '0;
        NOVA_RODADA:   pos <= '0;
        CARREGA:       leds <= mem_data;
        // Clearing on the last MOSTRA edge keeps the step lit for exactly SHOW_CYCLES clocks.
        MOSTRA:        if (t_fim) leds <= '0;
        APAGA:         leds <= '0;
        PROX_POS:      pos <= pos + ADDR_W'(1);
        INICIO_JOGADA: pos <= '0;
        REGISTRA:      jogada_reg <= botoes;
        PROX_JOGADA:   pos <= pos + ADDR_W'(1);
        FIM_RODADA:    if (rodada != ULTIMA) rodada <= rodada + ADDR_W'(1);
        default: ;
      endcase
    end
  end

`ifdef SEQ_GAME_TIMEOUT_EN
  logic timeout_flag;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timeout_flag <= 1'b0;
    end else if (estado == PREPARA) begin
      timeout_flag <= 1'b0;
    end else if ((estado == ESPERA) && !jogada && t_fim) begin
      timeout_flag <= 1'b1;
    end
  end

  assign db_timeout = timeout_flag;
`else
  assign db_timeout = 1'b0;
`endif

  assign mem_addr  = pos;
  assign acertou   = (estado == ACERTO);
  assign errou     = (estado == ERRO);
  assign pronto    = (estado == ACERTO) || (estado == ERRO);
  assign db_estado = estado;
  assign db_rodada = rodada;

endmodule
